// File: rtl/bsg_manycore_link_to_axil_tx.sv
// Host-to-manycore transmit path: packs ratio_lp AXI-Lite words into one host-FIFO packet,
// buffers up to tx_buf_els_p packets and reports free word slots to host software.
module bsg_manycore_link_to_axil_tx #(
    parameter int axil_data_width_p = 32,
    parameter int host_fifo_width_p = 128,
    parameter int tx_buf_els_p      = 2,
    localparam int ratio_lp         = host_fifo_width_p / axil_data_width_p,
    localparam int vacancy_width_lp = $clog2(ratio_lp * tx_buf_els_p + 1)
) (
    input  logic                         clk_i,
    input  logic                         reset_n_i,
    input  logic [axil_data_width_p-1:0] axil_data_i,
    input  logic                         axil_v_i,
    output logic                         axil_ready_o,
    output logic [host_fifo_width_p-1:0] fifo_data_o,
    output logic                         fifo_v_o,
    input  logic                         fifo_ready_i,
    output logic [vacancy_width_lp-1:0]  vacancy_o
);

    localparam int cnt_w_lp = (ratio_lp > 1) ? $clog2(ratio_lp) : 1;
    localparam int ptr_w_lp = (tx_buf_els_p > 1) ? $clog2(tx_buf_els_p) : 1;
    localparam int occ_w_lp = $clog2(tx_buf_els_p + 1);

    localparam logic [cnt_w_lp-1:0] cnt_last_lp = cnt_w_lp'(ratio_lp - 1);
    localparam logic [ptr_w_lp-1:0] ptr_last_lp = ptr_w_lp'(tx_buf_els_p - 1);
    localparam logic [occ_w_lp-1:0] occ_full_lp = occ_w_lp'(tx_buf_els_p);

    if (ratio_lp < 2 || ratio_lp * axil_data_width_p != host_fifo_width_p) begin : g_bad_params
        $fatal(1, "bsg_manycore_link_to_axil_tx: host_fifo_width_p must be an integer multiple (>=2) of axil_data_width_p");
    end

    logic [cnt_w_lp-1:0]          cnt_q, cnt_d;
    logic [occ_w_lp-1:0]          occ_q, occ_d;
    logic [ptr_w_lp-1:0]          wr_ptr_q, wr_ptr_d;
    logic [ptr_w_lp-1:0]          rd_ptr_q, rd_ptr_d;
    logic                         ready_q, ready_d;
    logic [axil_data_width_p-1:0] pack_q [ratio_lp-1];
    logic [host_fifo_width_p-1:0] mem_q  [tx_buf_els_p];
    logic [host_fifo_width_p-1:0] packet;
    logic                         accept, enq, deq;

    assign accept = axil_v_i & ready_q;
    assign enq    = accept & (cnt_q == cnt_last_lp);
    assign deq    = fifo_v_o & fifo_ready_i;

    // The final word bypasses the packing register so the packet enqueues on its own accept edge.
    always_comb begin
        packet = '0;
        for (int k = 0; k < ratio_lp - 1; k++) begin
            packet[k*axil_data_width_p +: axil_data_width_p] = pack_q[k];
        end
        packet[(ratio_lp-1)*axil_data_width_p +: axil_data_width_p] = axil_data_i;
    end

    always_comb begin
        cnt_d    = cnt_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;
        if (accept) begin
            cnt_d = enq ? '0 : cnt_q + cnt_w_lp'(1);
        end
        if (enq) begin
            wr_ptr_d = (wr_ptr_q == ptr_last_lp) ? '0 : wr_ptr_q + ptr_w_lp'(1);
        end
        if (deq) begin
            rd_ptr_d = (rd_ptr_q == ptr_last_lp) ? '0 : rd_ptr_q + ptr_w_lp'(1);
        end
        case ({enq, deq})
            2'b10:   occ_d = occ_q + occ_w_lp'(1);
            2'b01:   occ_d = occ_q - occ_w_lp'(1);
            default: occ_d = occ_q;
        endcase
        ready_d = (occ_d < occ_full_lp);
    end

    // Ready is a flop so it stays low through reset and never depends on this cycle's handshakes.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            cnt_q    <= '0;
            occ_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            ready_q  <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            occ_q    <= occ_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            ready_q  <= ready_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (accept && !enq) begin
            pack_q[cnt_q] <= axil_data_i;
        end
        if (enq) begin
            mem_q[wr_ptr_q] <= packet;
        end
    end

    assign axil_ready_o = ready_q;
    assign fifo_v_o     = (occ_q != '0);
    assign fifo_data_o  = mem_q[rd_ptr_q];
    assign vacancy_o    = vacancy_width_lp'(ratio_lp * tx_buf_els_p)
                        - vacancy_width_lp'(ratio_lp) * vacancy_width_lp'(occ_q)
                        - vacancy_width_lp'(cnt_q);

endmodule

// File: tb/tb_bsg_manycore_link_to_axil_tx.sv
// Bench for bsg_manycore_link_to_axil_tx: queue-based packet model checked every cycle,
// directed scenarios with literal expectations, and a random-backpressure scoreboard.
module tb_bsg_manycore_link_to_axil_tx;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [31:0]  axil_data = '0;
    logic         axil_v = 1'b0;
    logic         axil_ready;
    logic [127:0] fifo_data;
    logic         fifo_v;
    logic         fifo_ready = 1'b0;
    logic [3:0]   vacancy;

    always #5 clk = ~clk;

    bsg_manycore_link_to_axil_tx #(
        .axil_data_width_p(32),
        .host_fifo_width_p(128),
        .tx_buf_els_p(2)
    ) dut (
        .clk_i(clk),
        .reset_n_i(rst_n),
        .axil_data_i(axil_data),
        .axil_v_i(axil_v),
        .axil_ready_o(axil_ready),
        .fifo_data_o(fifo_data),
        .fifo_v_o(fifo_v),
        .fifo_ready_i(fifo_ready),
        .vacancy_o(vacancy)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    endtask

    function automatic logic [31:0] word_of(input int i);
        return 32'(i) * 32'h9E3779B1 + 32'h01234567;
    endfunction

    // Model: words of the packet being assembled, and packets waiting to be consumed.
    logic [31:0]  m_words[$];
    logic [127:0] m_pkts[$];
    bit           m_alive = 1'b0;

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            m_words.delete();
            m_pkts.delete();
            m_alive = 1'b0;
        end else begin
            bit acc, dq;
            logic [127:0] p;
            acc = axil_v && m_alive && (m_pkts.size() < 2);
            dq  = (m_pkts.size() != 0) && fifo_ready;
            if (dq) void'(m_pkts.pop_front());
            if (acc) begin
                m_words.push_back(axil_data);
                if (m_words.size() == 4) begin
                    p = '0;
                    for (int k = 0; k < 4; k++) p[k*32 +: 32] = m_words[k];
                    m_pkts.push_back(p);
                    m_words.delete();
                end
            end
            m_alive = 1'b1;
        end
    end

    initial forever begin
        @(negedge clk);
        if (!rst_n) begin
            check("rst_ready", 128'(axil_ready), 128'(0));
            check("rst_v", 128'(fifo_v), 128'(0));
            check("rst_vacancy", 128'(vacancy), 128'(8));
        end else begin
            int exp_vac;
            exp_vac = 4 * (2 - m_pkts.size()) - m_words.size();
            check("model_ready", 128'(axil_ready), 128'(m_alive && m_pkts.size() < 2));
            check("model_v", 128'(fifo_v), 128'(m_pkts.size() != 0));
            check("model_vacancy", 128'(vacancy), 128'(exp_vac));
            if (m_pkts.size() != 0) check("model_data", fifo_data, m_pkts[0]);
        end
    end

    // Random-phase scoreboard and output-stability monitor.
    bit           sb_en = 1'b0;
    int           n_out = 0;
    bit           prev_hold = 1'b0;
    logic [127:0] prev_data = '0;

    initial forever begin
        @(negedge clk);
        if (sb_en && rst_n) begin
            logic [127:0] exp_p;
            if (prev_hold) begin
                check("stable_v", 128'(fifo_v), 128'(1));
                check("stable_data", fifo_data, prev_data);
            end
            prev_hold = fifo_v && !fifo_ready;
            prev_data = fifo_data;
            if (fifo_v && fifo_ready) begin
                for (int k = 0; k < 4; k++) exp_p[k*32 +: 32] = word_of(4 * n_out + k);
                check("sb_packet", fifo_data, exp_p);
                n_out++;
            end
        end else begin
            prev_hold = 1'b0;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic write_word(input logic [31:0] d);
        axil_data = d;
        axil_v    = 1'b1;
        step();
        axil_v    = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        step();
    endtask

    initial begin
        logic [31:0] pw [4];
        int idx, cyc;
        bit acc;

        // reset state
        repeat (3) step();
        rst_n = 1'b1;
        step();
        check("release_ready", 128'(axil_ready), 128'(1));
        check("release_vacancy", 128'(vacancy), 128'(8));
        check("release_v", 128'(fifo_v), 128'(0));

        // packing order
        pw[0] = 32'h11111111; pw[1] = 32'h22222222; pw[2] = 32'h33333333; pw[3] = 32'h44444444;
        for (int i = 0; i < 4; i++) begin
            write_word(pw[i]);
            check("pack_vacancy", 128'(vacancy), 128'(7 - i));
        end
        check("pack_v", 128'(fifo_v), 128'(1));
        check("pack_data", fifo_data, 128'h44444444_33333333_22222222_11111111);
        fifo_ready = 1'b1;
        step();
        fifo_ready = 1'b0;
        check("pack_drained", 128'(fifo_v), 128'(0));

        // full buffer
        do_reset();
        idx = 0;
        axil_v = 1'b1;
        for (int c = 0; c < 12; c++) begin
            axil_data = 32'hF0000000 + 32'(idx);
            acc = axil_ready;
            step();
            if (acc) idx++;
        end
        check("full_accepted", 128'(idx), 128'(8));
        check("full_ready", 128'(axil_ready), 128'(0));
        check("full_vacancy", 128'(vacancy), 128'(0));
        axil_data  = 32'hF0000000 + 32'(idx);
        fifo_ready = 1'b1;
        acc = axil_ready;
        step();
        fifo_ready = 1'b0;
        if (acc) idx++;
        check("full_no_accept_on_deq", 128'(idx), 128'(8));
        check("full_vacancy_after_deq", 128'(vacancy), 128'(4));
        check("full_ready_after_deq", 128'(axil_ready), 128'(1));
        acc = axil_ready;
        step();
        if (acc) idx++;
        axil_v = 1'b0;
        check("full_ninth_accepted", 128'(idx), 128'(9));
        check("full_vacancy_after_ninth", 128'(vacancy), 128'(3));

        // simultaneous enqueue and dequeue with one packet buffered
        do_reset();
        for (int i = 0; i < 4; i++) write_word(32'hA0A0A0A0 + 32'(i));
        for (int i = 0; i < 3; i++) write_word(32'hB0B0B0B0 + 32'(i));
        check("simul_vacancy_pre", 128'(vacancy), 128'(1));
        axil_data  = 32'hB0B0B0B3;
        axil_v     = 1'b1;
        fifo_ready = 1'b1;
        step();
        axil_v     = 1'b0;
        fifo_ready = 1'b0;
        check("simul_v", 128'(fifo_v), 128'(1));
        check("simul_head", fifo_data, 128'hB0B0B0B3_B0B0B0B2_B0B0B0B1_B0B0B0B0);
        check("simul_vacancy", 128'(vacancy), 128'(4));
        fifo_ready = 1'b1;
        step();
        fifo_ready = 1'b0;
        check("simul_drained", 128'(fifo_v), 128'(0));

        // reset mid-packet
        do_reset();
        write_word(32'hDEAD0001);
        write_word(32'hDEAD0002);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        check("midrst_vacancy", 128'(vacancy), 128'(8));
        write_word(32'h0A0A0A0A);
        write_word(32'h0B0B0B0B);
        write_word(32'h0C0C0C0C);
        write_word(32'h0D0D0D0D);
        check("midrst_v", 128'(fifo_v), 128'(1));
        check("midrst_data", fifo_data, 128'h0D0D0D0D_0C0C0C0C_0B0B0B0B_0A0A0A0A);
        fifo_ready = 1'b1;
        step();
        fifo_ready = 1'b0;
        check("midrst_single_packet", 128'(fifo_v), 128'(0));

        // random backpressure
        do_reset();
        sb_en = 1'b1;
        idx = 0;
        cyc = 0;
        while (idx < 1000 && cyc < 20000) begin
            axil_v     = 1'($urandom_range(0, 1));
            fifo_ready = 1'($urandom_range(0, 1));
            axil_data  = word_of(idx);
            acc = axil_v && axil_ready;
            step();
            if (acc) idx++;
            cyc++;
        end
        axil_v = 1'b0;
        check("rand_words_accepted", 128'(idx), 128'(1000));
        fifo_ready = 1'b1;
        cyc = 0;
        while (n_out < 250 && cyc < 100) begin
            step();
            cyc++;
        end
        fifo_ready = 1'b0;
        step();
        sb_en = 1'b0;
        check("rand_packets_out", 128'(n_out), 128'(250));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
